mem_wb_stage: RTL and testbench

Memory/writeback stage directly downstream of the 16-bit IF/ID/EX pipeline. It consumes the EX result: ALU output, store data, destination register and control bits. It performs data-memory access for LW/SW through an internal word RAM with configurable latency. It drives the register-file write port (regwrite, wr, wd) and stalls EX while a memory access is outstanding.

---
 rtl/mem_wb_stage.sv | 143 ++++++++++++++
 tb/tb_mem_wb_stage.sv | 210 +++++++++++++++++++++
 2 files changed

// File: rtl/mem_wb_stage.sv
// rtl/mem_wb_stage.sv - memory/writeback stage with internal word RAM and stall on outstanding access
module mem_wb_stage #(
    parameter int DATA_W      = 16,
    parameter int DEPTH       = 256,
    parameter int MEM_LATENCY = 2,
    localparam int AW         = $clog2(DEPTH)
) (
    input  logic              clock,
    input  logic              reset_n,
    input  logic              ex_valid,
    input  logic [DATA_W-1:0] ex_alu_out,
    input  logic [DATA_W-1:0] ex_store_data,
    input  logic [1:0]        ex_wr,
    input  logic              ex_regwrite,
    input  logic              ex_memtoreg,
    input  logic              ex_memwrite,
    output logic              stall,
    output logic              wb_regwrite,
    output logic [1:0]        wb_wr,
    output logic [DATA_W-1:0] wb_wd,
    output logic              err,
    input  logic [AW-1:0]     dbg_addr,
    output logic [DATA_W-1:0] dbg_data
);

    // Count only needs to hold MEM_LATENCY-1; keep at least one bit so L=1 still elaborates.
    localparam int CW = (MEM_LATENCY > 2) ? $clog2(MEM_LATENCY) : 1;

    typedef enum logic {IDLE, BUSY} state_t;

    state_t            state;
    logic [CW-1:0]     count;
    logic [AW-1:0]     busy_idx;
    logic [DATA_W-1:0] busy_data;
    logic [1:0]        busy_wr;
    logic              busy_lw;

    logic [DATA_W-1:0] ram [DEPTH];

    logic [AW-1:0]     ex_idx;
    logic              accept;
    logic              ex_mem_op;
    logic              misaligned;
    logic              busy_done;
    logic              ram_we;
    logic [AW-1:0]     ram_widx;
    logic [DATA_W-1:0] ram_wdata;
    logic              unused_addr_bits;

    // Byte address to word index; upper bits drop out so addresses wrap modulo DEPTH.
    assign ex_idx           = ex_alu_out[AW:1];
    assign unused_addr_bits = ^ex_alu_out[DATA_W-1:AW+1];
    assign accept           = (state == IDLE) && ex_valid;
    assign ex_mem_op        = ex_memtoreg || ex_memwrite;
    assign misaligned       = ex_alu_out[0];
    assign busy_done        = (state == BUSY) && (count == CW'(1));
    assign dbg_data         = ram[dbg_addr];

    // RAM write port: immediate store at L=1, otherwise on the final BUSY edge; never while in reset.
    always_comb begin
        ram_we    = 1'b0;
        ram_widx  = busy_idx;
        ram_wdata = busy_data;
        if (MEM_LATENCY == 1) begin
            ram_we    = reset_n && accept && ex_memwrite && !misaligned;
            ram_widx  = ex_idx;
            ram_wdata = ex_store_data;
        end else begin
            ram_we    = reset_n && busy_done && !busy_lw;
        end
    end

    // Data RAM storage; contents survive reset.
    always_ff @(negedge clock) begin
        if (ram_we) begin
            ram[ram_widx] <= ram_wdata;
        end
    end

    // Stage control: capture from EX, run the multi-cycle access, drive one-cycle writeback.
    always_ff @(negedge clock or negedge reset_n) begin
        if (!reset_n) begin
            state       <= IDLE;
            count       <= '0;
            busy_idx    <= '0;
            busy_data   <= '0;
            busy_wr     <= '0;
            busy_lw     <= 1'b0;
            stall       <= 1'b0;
            wb_regwrite <= 1'b0;
            wb_wr       <= '0;
            wb_wd       <= '0;
            err         <= 1'b0;
        end else begin
            wb_regwrite <= 1'b0;
            err         <= 1'b0;
            case (state)
                IDLE: begin
                    stall <= 1'b0;
                    if (accept) begin
                        if (!ex_mem_op) begin
                            wb_regwrite <= ex_regwrite && (ex_wr != 2'd0);
                            wb_wr       <= ex_wr;
                            wb_wd       <= ex_alu_out;
                        end else if (misaligned) begin
                            err <= 1'b1;
                        end else if (MEM_LATENCY == 1) begin
                            if (ex_memtoreg) begin
                                wb_regwrite <= (ex_wr != 2'd0);
                                wb_wr       <= ex_wr;
                                wb_wd       <= ram[ex_idx];
                            end
                        end else begin
                            state     <= BUSY;
                            count     <= CW'(MEM_LATENCY - 1);
                            busy_idx  <= ex_idx;
                            busy_data <= ex_store_data;
                            busy_wr   <= ex_wr;
                            busy_lw   <= ex_memtoreg;
                            stall     <= 1'b1;
                        end
                    end
                end
                BUSY: begin
                    if (busy_done) begin
                        state <= IDLE;
                        stall <= 1'b0;
                        count <= '0;
                        if (busy_lw) begin
                            wb_regwrite <= (busy_wr != 2'd0);
                            wb_wr       <= busy_wr;
                            wb_wd       <= ram[busy_idx];
                        end
                    end else begin
                        count <= count - CW'(1);
                    end
                end
                default: state <= IDLE;
            endcase
        end
    end

endmodule

// File: tb/tb_mem_wb_stage.sv
// tb/tb_mem_wb_stage.sv - randomized self-checking bench for mem_wb_stage against a transaction-level model
module tb_mem_wb_stage;

    localparam int DATA_W = 16;
    localparam int DEPTH  = 256;
    localparam int L      = 2;
    localparam int AW     = $clog2(DEPTH);

    localparam int OP_ALU = 0;
    localparam int OP_LW  = 1;
    localparam int OP_SW  = 2;

    logic              clock = 1'b0;
    logic              reset_n;
    logic              ex_valid;
    logic [DATA_W-1:0] ex_alu_out;
    logic [DATA_W-1:0] ex_store_data;
    logic [1:0]        ex_wr;
    logic              ex_regwrite;
    logic              ex_memtoreg;
    logic              ex_memwrite;
    logic              stall;
    logic              wb_regwrite;
    logic [1:0]        wb_wr;
    logic [DATA_W-1:0] wb_wd;
    logic              err;
    logic [AW-1:0]     dbg_addr;
    logic [DATA_W-1:0] dbg_data;

    always #5 clock = ~clock;

    mem_wb_stage #(.DATA_W(DATA_W), .DEPTH(DEPTH), .MEM_LATENCY(L)) dut (
        .clock(clock), .reset_n(reset_n), .ex_valid(ex_valid), .ex_alu_out(ex_alu_out),
        .ex_store_data(ex_store_data), .ex_wr(ex_wr), .ex_regwrite(ex_regwrite),
        .ex_memtoreg(ex_memtoreg), .ex_memwrite(ex_memwrite), .stall(stall),
        .wb_regwrite(wb_regwrite), .wb_wr(wb_wr), .wb_wd(wb_wd), .err(err),
        .dbg_addr(dbg_addr), .dbg_data(dbg_data)
    );

    int n_checks = 0;
    int n_fail   = 0;

    logic [DATA_W-1:0] model_mem [DEPTH];
    bit                model_ok  [DEPTH];
    logic [1:0]        exp_wr;
    logic [DATA_W-1:0] exp_wd;
    bit                hold_known;

    task automatic check(input string tag, input logic [31:0] got, input logic [31:0] exp);
        n_checks++;
        if (got !== exp) begin
            n_fail++;
            $display("FAIL %s: got 0x%0h expected 0x%0h", tag, got, exp);
        end
    endtask

    // One instruction from EX, held until the stage finishes with it; sampled on rising edges.
    task automatic run_op(input int kind, input logic [15:0] addr, input logic [15:0] data,
                          input logic [1:0] wr, input logic rw);
        int idx;
        bit mis;
        ex_valid      = 1'b1;
        ex_alu_out    = addr;
        ex_store_data = data;
        ex_wr         = wr;
        ex_regwrite   = rw;
        ex_memtoreg   = (kind == OP_LW);
        ex_memwrite   = (kind == OP_SW);
        idx = (int'(addr) / 2) % DEPTH;
        mis = (kind != OP_ALU) && (addr % 2 == 1);
        @(negedge clock);
        @(posedge clock);
        if (kind != OP_ALU && !mis) begin
            for (int c = 0; c < L - 1; c++) begin
                check("stall_busy", stall, 1);
                check("bubble", wb_regwrite, 0);
                @(negedge clock);
                @(posedge clock);
            end
        end
        check("stall_done", stall, 0);
        check("err", err, mis);
        if (mis) begin
            check("mis_regwrite", wb_regwrite, 0);
            hold_known = 0;
        end else if (kind == OP_ALU) begin
            exp_wr = wr;
            exp_wd = addr;
            hold_known = 1;
            check("alu_regwrite", wb_regwrite, rw && (wr != 0));
            check("alu_wr", wb_wr, exp_wr);
            check("alu_wd", wb_wd, exp_wd);
        end else if (kind == OP_LW) begin
            check("lw_regwrite", wb_regwrite, wr != 0);
            check("lw_wr", wb_wr, wr);
            if (model_ok[idx]) begin
                exp_wr = wr;
                exp_wd = model_mem[idx];
                hold_known = 1;
                check("lw_wd", wb_wd, exp_wd);
            end else begin
                hold_known = 0;
            end
        end else begin
            model_mem[idx] = data;
            model_ok[idx]  = 1;
            hold_known     = 0;
            check("sw_regwrite", wb_regwrite, 0);
            dbg_addr = AW'(idx);
            #1;
            check("sw_dbg", dbg_data, model_mem[idx]);
        end
    endtask

    task automatic idle_cycle();
        ex_valid = 1'b0;
        @(negedge clock);
        @(posedge clock);
        check("idle_regwrite", wb_regwrite, 0);
        check("idle_stall", stall, 0);
        check("idle_err", err, 0);
        if (hold_known) begin
            check("idle_wr_hold", wb_wr, exp_wr);
            check("idle_wd_hold", wb_wd, exp_wd);
        end
    endtask

    initial begin
        reset_n = 1'b0; ex_valid = 1'b0; ex_alu_out = '0; ex_store_data = '0; ex_wr = '0;
        ex_regwrite = 1'b0; ex_memtoreg = 1'b0; ex_memwrite = 1'b0; dbg_addr = '0;
        hold_known = 0; exp_wr = '0; exp_wd = '0;
        for (int i = 0; i < DEPTH; i++) begin
            model_ok[i]  = 0;
            model_mem[i] = '0;
        end
        #12;
        check("rst_stall", stall, 0);
        check("rst_regwrite", wb_regwrite, 0);
        check("rst_wr", wb_wr, 0);
        check("rst_wd", wb_wd, 0);
        check("rst_err", err, 0);
        @(posedge clock);
        reset_n = 1'b1;

        run_op(OP_ALU, 16'h000F, 16'h0000, 2'd1, 1'b1);
        run_op(OP_SW, 16'h0010, 16'hBEEF, 2'd0, 1'b0);
        run_op(OP_LW, 16'h0010, 16'h0000, 2'd2, 1'b1);
        check("lw_beef", wb_wd, 16'hBEEF);
        run_op(OP_LW, 16'h0011, 16'h0000, 2'd2, 1'b1);
        idle_cycle();
        dbg_addr = AW'(8);
        #1;
        check("mis_ram_kept", dbg_data, 16'hBEEF);
        run_op(OP_SW, 16'h0202, 16'h1234, 2'd0, 1'b0);
        dbg_addr = AW'(1);
        #1;
        check("wrap_dbg", dbg_data, 16'h1234);

        run_op(OP_SW, 16'h0004, 16'hAAAA, 2'd0, 1'b0);
        ex_valid = 1'b1; ex_alu_out = 16'h0004; ex_store_data = 16'h5555;
        ex_memwrite = 1'b1; ex_memtoreg = 1'b0;
        @(negedge clock);
        @(posedge clock);
        check("pre_rst_stall", stall, 1);
        reset_n = 1'b0;
        ex_valid = 1'b0;
        #1;
        check("midrst_stall", stall, 0);
        check("midrst_regwrite", wb_regwrite, 0);
        check("midrst_wr", wb_wr, 0);
        check("midrst_wd", wb_wd, 0);
        check("midrst_err", err, 0);
        @(negedge clock);
        @(posedge clock);
        reset_n = 1'b1;
        exp_wr = '0; exp_wd = '0; hold_known = 1;
        dbg_addr = AW'(2);
        #1;
        check("midrst_ram_kept", dbg_data, 16'hAAAA);
        idle_cycle();

        run_op(OP_ALU, 16'h1357, 16'h0000, 2'd0, 1'b1);
        for (int i = 0; i < 20; i++) begin
            run_op(OP_ALU, 16'($urandom), 16'h0000, 2'($urandom), 1'($urandom));
        end

        for (int i = 0; i < 16; i++) begin
            run_op(OP_SW, 16'(i * 2), 16'($urandom), 2'd0, 1'b0);
        end
        for (int i = 0; i < 300; i++) begin
            int kind;
            int idx;
            int hi;
            logic [15:0] a;
            kind = $urandom_range(0, 2);
            idx  = $urandom_range(0, 15);
            hi   = $urandom_range(0, 127);
            a    = 16'((hi * DEPTH + idx) * 2);
            if (kind != OP_ALU && $urandom_range(0, 9) == 0) a = a + 16'd1;
            if (kind == OP_ALU) a = 16'($urandom);
            run_op(kind, a, 16'($urandom), 2'($urandom), 1'($urandom));
            if ($urandom_range(0, 5) == 0) idle_cycle();
        end
        idle_cycle();

        $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
        $finish;
    end

endmodule
